// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef logic port_t;
  localparam port_t PORT_DATA = 1'b0;
  localparam port_t PORT_FETCH = 1'b1;
  localparam int TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: data port, fetch port and memory bus bundle
interface mem_port_arbiter_if;
  logic d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic mem_en, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  modport slave (
    input d_req, d_we, d_addr, d_wdata, f_req, f_addr, mem_rdata, mem_ready,
    output d_gnt, d_rvalid, d_rdata, d_err, f_gnt, f_rvalid, f_rdata, f_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output d_req, d_we, d_addr, d_wdata, f_req, f_addr, mem_rdata, mem_ready,
    input d_gnt, d_rvalid, d_rdata, d_err, f_gnt, f_rvalid, f_rdata, f_err,
    input mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin pick between data and fetch requests
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic  d_req,
  input  logic  f_req,
  input  port_t last_grant,
  output port_t winner,
  output logic  valid
);
  assign valid = d_req | f_req;
  assign winner = (d_req && f_req) ? ~last_grant : (d_req ? PORT_DATA : PORT_FETCH);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-outstanding arbiter of data and fetch ports onto one memory bus
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  state_t state_q;
  port_t winner_q, last_grant_q, rr_winner;
  logic rr_valid, done;
  logic [7:0] cnt_q;
  logic d_gnt_q, f_gnt_q, d_rvalid_q, f_rvalid_q, d_err_q, f_err_q, mem_en_q, mem_we_q;
  logic [31:0] d_rdata_q, f_rdata_q, mem_addr_q, mem_wdata_q, rdata_d;
  mem_arb_rr u_rr (
    .d_req(bus.d_req),
    .f_req(bus.f_req),
    .last_grant(last_grant_q),
    .winner(rr_winner),
    .valid(rr_valid)
  );
  // mem_ready wins over the timeout when both land on the last allowed cycle
  assign done = (state_q == ACCESS) && (bus.mem_ready || cnt_q == 8'(TIMEOUT - 1));
  assign rdata_d = (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      winner_q <= PORT_DATA;
      last_grant_q <= PORT_FETCH;
      cnt_q <= '0;
      d_gnt_q <= 1'b0;
      f_gnt_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_err_q <= 1'b0;
      f_err_q <= 1'b0;
      d_rdata_q <= '0;
      f_rdata_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      d_gnt_q <= 1'b0;
      f_gnt_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_err_q <= 1'b0;
      f_err_q <= 1'b0;
      d_rdata_q <= '0;
      f_rdata_q <= '0;
      if (state_q == IDLE) begin
        if (rr_valid) begin
          state_q <= ACCESS;
          winner_q <= rr_winner;
          last_grant_q <= rr_winner;
          cnt_q <= '0;
          d_gnt_q <= rr_winner == PORT_DATA;
          f_gnt_q <= rr_winner == PORT_FETCH;
          mem_en_q <= 1'b1;
          mem_we_q <= (rr_winner == PORT_DATA) && bus.d_we;
          mem_addr_q <= (rr_winner == PORT_DATA) ? bus.d_addr : bus.f_addr;
          mem_wdata_q <= (rr_winner == PORT_DATA) ? bus.d_wdata : '0;
        end
      end else if (done) begin
        state_q <= IDLE;
        mem_en_q <= 1'b0;
        mem_we_q <= 1'b0;
        mem_addr_q <= '0;
        mem_wdata_q <= '0;
        d_rvalid_q <= winner_q == PORT_DATA;
        f_rvalid_q <= winner_q == PORT_FETCH;
        d_rdata_q <= (winner_q == PORT_DATA) ? rdata_d : '0;
        f_rdata_q <= (winner_q == PORT_FETCH) ? rdata_d : '0;
        d_err_q <= (winner_q == PORT_DATA) && !bus.mem_ready;
        f_err_q <= (winner_q == PORT_FETCH) && !bus.mem_ready;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end
  assign bus.d_gnt = d_gnt_q;
  assign bus.f_gnt = f_gnt_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.d_err = d_err_q;
  assign bus.f_err = f_err_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.f_rdata = f_rdata_q;
  assign bus.mem_en = mem_en_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios then random traffic against a transaction-level model
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int T = 16;
  localparam logic D = 1'b0;
  localparam logic F = 1'b1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ":flags"}, 32'({bus.d_gnt, bus.d_rvalid, bus.d_err, bus.f_gnt,
                              bus.f_rvalid, bus.f_err, bus.mem_en, bus.mem_we}), 32'h0);
    chk({tag, ":d_rdata"}, bus.d_rdata, 32'h0);
    chk({tag, ":f_rdata"}, bus.f_rdata, 32'h0);
    chk({tag, ":mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, ":mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  logic exp_p, busy, last, win, dq, fq, gwe, err;
  logic [31:0] ga, gwd, data;
  int acc, lat;

  initial begin
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.f_req = 0; bus.f_addr = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    #12;
    chk_quiet("reset");
    reset = 0;
    // single load, ready in first ACCESS cycle
    bus.d_req = 1; bus.d_addr = 32'h10;
    tick;
    chk("ld:d_gnt", bus.d_gnt, 1); chk("ld:f_gnt", bus.f_gnt, 0);
    chk("ld:mem_en", bus.mem_en, 1); chk("ld:mem_we", bus.mem_we, 0);
    chk("ld:mem_addr", bus.mem_addr, 32'h10);
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    tick;
    chk("ld:d_rvalid", bus.d_rvalid, 1); chk("ld:d_rdata", bus.d_rdata, 32'hDEADBEEF);
    chk("ld:d_err", bus.d_err, 0); chk("ld:d_gnt_off", bus.d_gnt, 0);
    chk("ld:mem_en_off", bus.mem_en, 0); chk("ld:f_rvalid", bus.f_rvalid, 0);
    bus.d_req = 0;
    tick;
    chk_quiet("idle_ready");
    bus.mem_ready = 0;
    // contention from reset alternates D,F,D,F
    reset = 1; tick; reset = 0;
    bus.d_req = 1; bus.f_req = 1; bus.d_addr = 32'h100; bus.f_addr = 32'h200;
    exp_p = D;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr:d_gnt", bus.d_gnt, exp_p == D); chk("rr:f_gnt", bus.f_gnt, exp_p == F);
      chk("rr:mem_addr", bus.mem_addr, exp_p == F ? 32'h200 : 32'h100);
      bus.mem_ready = 1; bus.mem_rdata = hash(i);
      tick;
      chk("rr:d_rvalid", bus.d_rvalid, exp_p == D); chk("rr:f_rvalid", bus.f_rvalid, exp_p == F);
      chk("rr:d_rdata", bus.d_rdata, exp_p == D ? hash(i) : 0);
      chk("rr:f_rdata", bus.f_rdata, exp_p == F ? hash(i) : 0);
      bus.mem_ready = 0;
      exp_p = !exp_p;
    end
    bus.d_req = 0; bus.f_req = 0;
    tick;
    // store held for several cycles before ready
    bus.d_req = 1; bus.d_we = 1; bus.d_wdata = 32'h12345678; bus.d_addr = 32'h20;
    tick;
    chk("st:d_gnt", bus.d_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      chk("st:mem_en", bus.mem_en, 1); chk("st:mem_we", bus.mem_we, 1);
      chk("st:mem_wdata", bus.mem_wdata, 32'h12345678); chk("st:mem_addr", bus.mem_addr, 32'h20);
      chk("st:early_rvalid", bus.d_rvalid, 0);
      tick;
    end
    bus.mem_ready = 1; bus.mem_rdata = 32'hCAFEF00D;
    tick;
    chk("st:d_rvalid", bus.d_rvalid, 1); chk("st:d_rdata", bus.d_rdata, 0); chk("st:d_err", bus.d_err, 0);
    bus.d_req = 0; bus.d_we = 0; bus.mem_ready = 0;
    tick;
    // fetch timeout after T ACCESS cycles
    bus.f_req = 1; bus.f_addr = 32'h300; bus.mem_rdata = 32'hBADBAD00;
    tick;
    chk("to:f_gnt", bus.f_gnt, 1);
    for (int i = 1; i < T; i++) begin
      tick;
      chk("to:mem_en_held", bus.mem_en, 1);
      chk("to:early_rvalid", bus.f_rvalid, 0);
    end
    tick;
    chk("to:f_rvalid", bus.f_rvalid, 1); chk("to:f_err", bus.f_err, 1);
    chk("to:f_rdata", bus.f_rdata, 0); chk("to:mem_en", bus.mem_en, 0);
    chk("to:d_rvalid", bus.d_rvalid, 0);
    // async reset mid-ACCESS, then pending data wins
    tick;
    chk("ar:f_gnt", bus.f_gnt, 1);
    bus.d_req = 1; bus.d_addr = 32'h40;
    tick;
    #2 reset = 1;
    #1 chk_quiet("async_rst");
    bus.mem_ready = 1;
    tick;
    chk_quiet("rst_hold");
    reset = 0; bus.mem_ready = 0;
    tick;
    chk("ar:d_gnt", bus.d_gnt, 1); chk("ar:f_gnt", bus.f_gnt, 0);
    chk("ar:mem_addr", bus.mem_addr, 32'h40);
    bus.mem_ready = 1; bus.mem_rdata = 32'h0BADCAFE;
    tick;
    chk("ar:d_rvalid", bus.d_rvalid, 1); chk("ar:d_rdata", bus.d_rdata, 32'h0BADCAFE);
    bus.d_req = 0; bus.f_req = 0; bus.mem_ready = 0;
    tick;
    // random traffic
    reset = 1; tick; reset = 0;
    busy = 0; last = F; acc = 0; lat = 0; win = D; ga = 0; gwe = 0; gwd = 0;
    for (int n = 0; n < 800; n++) begin
      if (!bus.d_req && $urandom_range(2) == 0) begin
        bus.d_req = 1; bus.d_we = 1'($urandom); bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
      if (!bus.f_req && $urandom_range(2) == 0) begin
        bus.f_req = 1; bus.f_addr = $urandom;
      end
      bus.mem_ready = busy && acc == lat;
      bus.mem_rdata = bus.mem_ready ? hash(bus.mem_addr) : $urandom;
      dq = bus.d_req; fq = bus.f_req;
      tick;
      if (!busy) begin
        if (dq || fq) begin
          win = dq ? (fq ? !last : D) : F;
          last = win; busy = 1; acc = 1;
          lat = ($urandom_range(99) < 12) ? T + 1 + $urandom_range(3) : $urandom_range(1, 6);
          ga = win == D ? bus.d_addr : bus.f_addr;
          gwe = win == D && bus.d_we;
          gwd = win == D ? bus.d_wdata : 0;
          chk("rnd:d_gnt", bus.d_gnt, win == D); chk("rnd:f_gnt", bus.f_gnt, win == F);
        end else begin
          chk("rnd:d_gnt_idle", bus.d_gnt, 0); chk("rnd:f_gnt_idle", bus.f_gnt, 0);
        end
        chk("rnd:d_rvalid_idle", bus.d_rvalid, 0); chk("rnd:f_rvalid_idle", bus.f_rvalid, 0);
      end else if (acc == lat || acc == T) begin
        err = acc != lat;
        data = (err || gwe) ? 0 : hash(ga);
        busy = 0;
        chk("rnd:d_rvalid", bus.d_rvalid, win == D); chk("rnd:f_rvalid", bus.f_rvalid, win == F);
        chk("rnd:d_err", bus.d_err, win == D && err); chk("rnd:f_err", bus.f_err, win == F && err);
        chk("rnd:d_rdata", bus.d_rdata, win == D ? data : 0);
        chk("rnd:f_rdata", bus.f_rdata, win == F ? data : 0);
        if (win == D) bus.d_req = 0; else bus.f_req = 0;
      end else begin
        acc++;
        chk("rnd:busy_quiet", 32'({bus.d_gnt, bus.f_gnt, bus.d_rvalid, bus.f_rvalid}), 0);
      end
      chk("rnd:mem_en", bus.mem_en, busy);
      if (busy) begin
        chk("rnd:mem_addr", bus.mem_addr, ga);
        chk("rnd:mem_we", bus.mem_we, gwe);
        chk("rnd:mem_wdata", bus.mem_wdata, gwd);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT, 16, max cycles in ACCESS awaiting mem_ready before abort (range 2..255).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 d_req  in  1  data-port (MEM stage) request; held until d_rvalid.
REQ-005 d_we  in  1  data-port write enable (1=store, 0=load).
REQ-006 d_addr  in  32  data-port byte address.
REQ-007 d_wdata  in  32  data-port store data.
REQ-008 d_gnt  out  1  one-cycle pulse: data request accepted.
REQ-009 d_rvalid  out  1  one-cycle pulse: data access complete.
REQ-010 d_rdata  out  32  load data, valid with d_rvalid.
REQ-011 d_err  out  1  timeout flag, valid with d_rvalid.
REQ-012 f_req  in  1  fetch-port (IF stage) read request; held until f_rvalid.
REQ-013 f_addr  in  32  fetch byte address.
REQ-014 f_gnt  out  1  one-cycle pulse: fetch accepted.
REQ-015 f_rvalid  out  1  one-cycle pulse: fetch complete.
REQ-016 f_rdata  out  32  instruction word, valid with f_rvalid.
REQ-017 f_err  out  1  timeout flag, valid with f_rvalid.
REQ-018 mem_en  out  1  memory access active; held until mem_ready or abort.
REQ-019 mem_we  out  1  memory write enable, valid with mem_en.
REQ-020 mem_addr  out  32  memory byte address (big-endian word at addr..addr+3).
REQ-021 mem_wdata  out  32  memory store data.
REQ-022 mem_rdata  in  32  memory read data, sampled when mem_ready=1.
REQ-023 mem_ready  in  1  memory completes current access this cycle.

Function
REQ-024 FSM SHALL have states IDLE and ACCESS; single outstanding access.
REQ-025 IDLE, any req at posedge: go ACCESS, register winner id, addr, we, wdata (fetch: we=0, wdata=0); winner gnt high the following cycle only.
REQ-026 Both req in IDLE: grant port not granted last (round-robin via last_grant); single req always granted.
REQ-027 mem_en, mem_we, mem_addr, mem_wdata SHALL be registered, driven from ACCESS entry, stable until exit; mem_en=0 in IDLE.
REQ-028 ACCESS with mem_ready=1 at posedge: go IDLE, winner rvalid pulses next cycle, rdata=mem_rdata (0 for stores), err=0.
REQ-029 Timeout counter SHALL clear on ACCESS entry, increment each ACCESS cycle; at TIMEOUT cycles without mem_ready: go IDLE, rvalid pulse, err=1, rdata=0.
REQ-030 mem_ready sampled in IDLE SHALL be ignored.
REQ-031 req still high in rvalid cycle SHALL be treated as a new request, arbitrated at next posedge; minimum period 2 cycles per access.
REQ-032 rdata/err of non-winning port SHALL stay 0; at most one gnt and one rvalid high per cycle.
REQ-033 Minimum latency: req sampled edge E0, rvalid high after E1 when mem_ready=1 in first ACCESS cycle.

Reset
REQ-034 reset SHALL force IDLE, last_grant=fetch (data wins first tie), counter=0, every output 0, immediately and asynchronously.
REQ-035 reset during ACCESS SHALL abandon the access with no rvalid; requesters must re-request.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum, port-id constants (PORT_DATA=0, PORT_FETCH=1) and default TIMEOUT.
REQ-037 Round-robin selection SHALL be sub-module mem_arb_rr (inputs d_req, f_req, last_grant; output winner, valid).

Verification
REQ-038 d_req=1, d_we=0, d_addr=0x10, mem_ready=1 after 1 cycle, mem_rdata=0xDEADBEEF -> d_gnt pulse, mem_addr=0x10, d_rvalid with d_rdata=0xDEADBEEF, d_err=0.
REQ-039 d_req and f_req both high from reset -> data granted first, then fetch; repeated contention alternates D,F,D,F.
REQ-040 d_we=1, d_wdata=0x12345678, addr 0x20 -> mem_we=1, mem_wdata=0x12345678 until mem_ready; d_rvalid with d_rdata=0.
REQ-041 f_req=1, mem_ready held 0 -> after 16 ACCESS cycles f_rvalid=1, f_err=1, f_rdata=0, mem_en drops.
REQ-042 reset pulsed mid-ACCESS -> all outputs 0 immediately, no rvalid; after release a pending d_req is granted first.
